// File: rtl/game_pkg.sv
// Shared types and constants for the boss-level projectile logic.
package game_pkg;

  localparam int unsigned COORD_W  = 10;
  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  typedef enum logic [1:0] {
    IDLE,
    FLIGHT,
    HIT
  } slot_state_t;

  // Unsigned absolute difference of two screen coordinates.
  function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/projectile_slot.sv
// One projectile slot: state machine, position registers and target hit compare.
// Ports: Clk/Reset (async active-low); tick = frame update strobe; launch loads
// launch_x/launch_y; hit_en gates hit detection; x_pos/y_pos/active registered;
// idle_c and hit_c are combinational views of the current (pre-move) slot.
module projectile_slot
  import game_pkg::*;
#(
  parameter int unsigned SPEED         = 4,
  parameter int unsigned HIT_THRESHOLD = 50
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               tick,
  input  logic               launch,
  input  logic               hit_en,
  input  logic [COORD_W-1:0] launch_x,
  input  logic [COORD_W-1:0] launch_y,
  input  logic [COORD_W-1:0] target_x,
  input  logic [COORD_W-1:0] target_y,
  output logic [COORD_W-1:0] x_pos,
  output logic [COORD_W-1:0] y_pos,
  output logic               active,
  output logic               idle_c,
  output logic               hit_c
);

  localparam logic [COORD_W-1:0] SPEED_C = COORD_W'(SPEED);
  localparam logic [COORD_W-1:0] TH_C    = COORD_W'(HIT_THRESHOLD);

  slot_state_t state;

  assign idle_c = (state == IDLE);

  // Hit test looks at the position before this frame's move.
  assign hit_c = (state == FLIGHT) && hit_en &&
                 (abs_diff(x_pos, target_x) < TH_C) &&
                 (abs_diff(y_pos, target_y) < TH_C);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state  <= IDLE;
      x_pos  <= '0;
      y_pos  <= '0;
      active <= 1'b0;
    end else if (tick) begin
      case (state)
        IDLE: begin
          if (launch) begin
            state  <= FLIGHT;
            x_pos  <= launch_x;
            y_pos  <= launch_y;
            active <= 1'b1;
          end
        end
        FLIGHT: begin
          // A hit takes priority over leaving the top of the screen.
          if (hit_c) begin
            state  <= HIT;
            active <= 1'b0;
          end else if (y_pos < SPEED_C) begin
            state  <= IDLE;
            active <= 1'b0;
          end else begin
            y_pos <= y_pos - SPEED_C;
          end
        end
        HIT: begin
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/boss_projectile_pool.sv
// Pool of player projectiles for boss levels: frame tick sync, slot allocation,
// launch cooldown, hit counting, boss hit points, score and win state.
// Ports: Clk/Reset (async active-low); frame_clk raw vsync-rate clock; shoot
// fire request; player/target positions in; per-slot positions and
// slot_active, hit_pulse, boss_hp, boss_dead, score out (all registered).
module boss_projectile_pool
  import game_pkg::*;
#(
  parameter int unsigned NUM_SLOTS       = 3,
  parameter int unsigned SPEED           = 4,
  parameter int unsigned HIT_THRESHOLD   = 50,
  parameter int unsigned BOSS_HP         = 8,
  parameter int unsigned COOLDOWN_FRAMES = 6,
  parameter int unsigned PTS_PER_HIT     = 10
) (
  input  logic                              Clk,
  input  logic                              Reset,
  input  logic                              frame_clk,
  input  logic                              shoot,
  input  logic [COORD_W-1:0]                player_x_pos,
  input  logic [COORD_W-1:0]                player_y_pos,
  input  logic [COORD_W-1:0]                target_x_pos,
  input  logic [COORD_W-1:0]                target_y_pos,
  output logic [NUM_SLOTS-1:0][COORD_W-1:0] proj_x_pos,
  output logic [NUM_SLOTS-1:0][COORD_W-1:0] proj_y_pos,
  output logic [NUM_SLOTS-1:0]              slot_active,
  output logic                              hit_pulse,
  output logic [7:0]                        boss_hp,
  output logic                              boss_dead,
  output logic [15:0]                       score
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CD_W    = 8;
  localparam int unsigned SCORE_W = 16;

  logic [2:0]           fsync;
  logic                 tick;
  logic [CD_W-1:0]      cooldown;
  logic [NUM_SLOTS-1:0] idle_c;
  logic [NUM_SLOTS-1:0] hit_c;
  logic [NUM_SLOTS-1:0] grant_c;
  logic                 launch_c;
  logic [CNT_W-1:0]     hit_cnt_c;
  logic [SCORE_W:0]     score_sum_c;

  // Two-flop synchroniser plus edge detect; tick is one Clk wide.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fsync <= '0;
      tick  <= 1'b0;
    end else begin
      fsync <= {fsync[1:0], frame_clk};
      tick  <= fsync[1] & ~fsync[2];
    end
  end

  // Lowest-index slot that is IDLE at the start of the tick.
  always_comb begin
    grant_c = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (idle_c[i]) grant_c = NUM_SLOTS'(1) << i;
    end
  end

  assign launch_c = tick && shoot && (cooldown == '0) && !boss_dead && (grant_c != '0);

  always_comb begin
    hit_cnt_c = '0;
    for (int i = 0; i < NUM_SLOTS; i++) hit_cnt_c = hit_cnt_c + CNT_W'(hit_c[i]);
  end

  assign score_sum_c = (SCORE_W + 1)'(score) +
                       (SCORE_W + 1)'(PTS_PER_HIT) * (SCORE_W + 1)'(hit_cnt_c);

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    projectile_slot #(
      .SPEED         (SPEED),
      .HIT_THRESHOLD (HIT_THRESHOLD)
    ) u_slot (
      .Clk      (Clk),
      .Reset    (Reset),
      .tick     (tick),
      .launch   (launch_c && grant_c[g]),
      .hit_en   (!boss_dead),
      .launch_x (player_x_pos),
      .launch_y (player_y_pos),
      .target_x (target_x_pos),
      .target_y (target_y_pos),
      .x_pos    (proj_x_pos[g]),
      .y_pos    (proj_y_pos[g]),
      .active   (slot_active[g]),
      .idle_c   (idle_c[g]),
      .hit_c    (hit_c[g])
    );
  end

  // Cooldown, hit points, score and win state.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cooldown  <= '0;
      hit_pulse <= 1'b0;
      boss_hp   <= 8'(BOSS_HP);
      boss_dead <= 1'b0;
      score     <= '0;
    end else begin
      hit_pulse <= 1'b0;
      boss_dead <= boss_dead | (boss_hp == '0);
      if (tick) begin
        if (launch_c) begin
          cooldown <= CD_W'(COOLDOWN_FRAMES);
        end else if (cooldown != '0) begin
          cooldown <= cooldown - CD_W'(1);
        end
        if (hit_cnt_c != '0) begin
          hit_pulse <= 1'b1;
          boss_hp   <= (8'(hit_cnt_c) >= boss_hp) ? 8'd0 : boss_hp - 8'(hit_cnt_c);
          score     <= score_sum_c[SCORE_W] ? 16'hFFFF : score_sum_c[SCORE_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_boss_projectile_pool.sv
// Directed bench for boss_projectile_pool with default parameters.
module tb_boss_projectile_pool;

  logic            Clk;
  logic            Reset;
  logic            frame_clk;
  logic            shoot;
  logic [9:0]      player_x_pos;
  logic [9:0]      player_y_pos;
  logic [9:0]      target_x_pos;
  logic [9:0]      target_y_pos;
  logic [2:0][9:0] proj_x_pos;
  logic [2:0][9:0] proj_y_pos;
  logic [2:0]      slot_active;
  logic            hit_pulse;
  logic [7:0]      boss_hp;
  logic            boss_dead;
  logic [15:0]     score;

  int n_vec = 0;
  int n_err = 0;
  int pulses = 0;

  boss_projectile_pool dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_clk    (frame_clk),
    .shoot        (shoot),
    .player_x_pos (player_x_pos),
    .player_y_pos (player_y_pos),
    .target_x_pos (target_x_pos),
    .target_y_pos (target_y_pos),
    .proj_x_pos   (proj_x_pos),
    .proj_y_pos   (proj_y_pos),
    .slot_active  (slot_active),
    .hit_pulse    (hit_pulse),
    .boss_hp      (boss_hp),
    .boss_dead    (boss_dead),
    .score        (score)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One frame_clk period; counts hit_pulse cycles seen during it.
  task automatic frame();
    pulses = 0;
    @(negedge Clk) frame_clk = 1'b1;
    repeat (6) begin
      @(negedge Clk);
      if (hit_pulse) pulses++;
    end
    frame_clk = 1'b0;
    repeat (4) begin
      @(negedge Clk);
      if (hit_pulse) pulses++;
    end
  endtask

  task automatic do_reset();
    @(negedge Clk) Reset = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
  endtask

  task automatic set_target(input int x, input int y);
    target_x_pos = 10'(x);
    target_y_pos = 10'(y);
  endtask

  task automatic set_player(input int x, input int y);
    player_x_pos = 10'(x);
    player_y_pos = 10'(y);
  endtask

  initial begin
    Reset = 1'b0;
    frame_clk = 1'b0;
    shoot = 1'b0;
    set_player(0, 0);
    set_target(0, 0);
    do_reset();

    check("rst_active", 32'(slot_active), 0);
    check("rst_hp", 32'(boss_hp), 8);
    check("rst_score", 32'(score), 0);

    // Held shoot with cooldown: launches on ticks 0, 7, 14; 4th dropped.
    set_player(320, 400);
    shoot = 1'b1;
    for (int k = 0; k <= 21; k++) begin
      frame();
      if (k == 0) begin
        check("t2_act0", 32'(slot_active), 3'b001);
        check("t2_x0", 32'(proj_x_pos[0]), 320);
        check("t2_y0", 32'(proj_y_pos[0]), 400);
      end
      if (k == 6) check("t2_cool", 32'(slot_active), 3'b001);
      if (k == 7) begin
        check("t2_act1", 32'(slot_active), 3'b011);
        check("t2_y1", 32'(proj_y_pos[1]), 400);
        check("t2_y0_k7", 32'(proj_y_pos[0]), 372);
      end
      if (k == 14) check("t2_act2", 32'(slot_active), 3'b111);
    end
    check("t2_drop", 32'(slot_active), 3'b111);
    check("t2_y2", 32'(proj_y_pos[2]), 372);
    check("t2_y0", 32'(proj_y_pos[0]), 316);
    shoot = 1'b0;

    // Asynchronous reset in mid-flight, observed before the next Clk edge.
    @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    check("t1_active", 32'(slot_active), 0);
    check("t1_hp", 32'(boss_hp), 8);
    check("t1_dead", 32'(boss_dead), 0);
    check("t1_pulse", 32'(hit_pulse), 0);
    check("t1_y0", 32'(proj_y_pos[0]), 0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);

    // Single shot runs off the top without wrapping.
    set_target(0, 0);
    set_player(320, 400);
    shoot = 1'b1;
    frame();
    shoot = 1'b0;
    frame();
    check("t3_y396", 32'(proj_y_pos[0]), 396);
    for (int k = 0; k < 99; k++) frame();
    check("t3_y0", 32'(proj_y_pos[0]), 0);
    check("t3_act_y0", 32'(slot_active), 3'b001);
    frame();
    check("t3_idle", 32'(slot_active), 0);
    check("t3_nowrap", 32'(proj_y_pos[0]), 0);

    // Two slots hit on the same tick.
    do_reset();
    set_target(0, 0);
    for (int k = 0; k <= 14; k++) begin
      shoot = (k == 0 || k == 7 || k == 14);
      if (k == 0) set_player(100, 400);
      if (k == 7) set_player(600, 400);
      if (k == 14) set_player(130, 400);
      frame();
    end
    shoot = 1'b0;
    check("t4_pre", 32'(slot_active), 3'b111);
    set_target(115, 370);
    frame();
    check("t4_hp", 32'(boss_hp), 6);
    check("t4_score", 32'(score), 20);
    check("t4_pulses", 32'(pulses), 1);
    check("t4_active", 32'(slot_active), 3'b010);
    check("t4_hold_y0", 32'(proj_y_pos[0]), 344);
    frame();
    check("t4_nohit_hp", 32'(boss_hp), 6);
    check("t4_nohit_pulse", 32'(pulses), 0);
    set_player(600, 400);
    shoot = 1'b1;
    for (int k = 17; k <= 20; k++) frame();
    check("t4_cool", 32'(slot_active), 3'b010);
    frame();
    check("t4_reuse", 32'(slot_active), 3'b011);
    check("t4_reuse_x", 32'(proj_x_pos[0]), 600);
    shoot = 1'b0;

    // Kill the boss, then hits and launches are ignored.
    do_reset();
    set_target(320, 200);
    shoot = 1'b1;
    for (int k = 0; k <= 57; k++) begin
      if (k == 49) set_player(600, 400);
      else set_player(320, 210);
      frame();
      if (k == 43) begin
        check("t5_hp1", 32'(boss_hp), 1);
        check("t5_score70", 32'(score), 70);
        check("t5_alive", 32'(boss_dead), 0);
      end
    end
    check("t5_hp0", 32'(boss_hp), 0);
    check("t5_score80", 32'(score), 80);
    check("t5_dead", 32'(boss_dead), 1);
    set_target(600, 350);
    pulses = 0;
    begin
      int total;
      total = 0;
      for (int k = 58; k <= 67; k++) begin
        frame();
        total += pulses;
      end
      check("t5_pulses", 32'(total), 0);
    end
    check("t5_score_hold", 32'(score), 80);
    check("t5_hp_hold", 32'(boss_hp), 0);
    check("t5_active", 32'(slot_active), 3'b001);
    check("t5_y0", 32'(proj_y_pos[0]), 328);
    shoot = 1'b0;

    // Hit at y=2 beats leaving the screen.
    do_reset();
    set_target(600, 400);
    set_player(200, 10);
    shoot = 1'b1;
    frame();
    shoot = 1'b0;
    frame();
    frame();
    check("t6_y2", 32'(proj_y_pos[0]), 2);
    set_target(200, 2);
    frame();
    check("t6_hp", 32'(boss_hp), 7);
    check("t6_score", 32'(score), 10);
    check("t6_pulse", 32'(pulses), 1);
    check("t6_active", 32'(slot_active), 0);
    check("t6_hold_y", 32'(proj_y_pos[0]), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
